apb_master_bridge: RTL

- Converts single-beat commands from a local valid/ready request port into APB transfers. Drives the SETUP/ACCESS sequence and honours slave wait states and PSLVERR.
- Returns read data and error status on a valid/ready response port.
- Sits between the test or CPU-side logic and APB register slaves. It also provides a bus-hang timeout so that a slave that never asserts PREADY cannot stall the initiator.

---
 rtl/apb_master_bridge.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// Single-outstanding bridge from a valid/ready command port to an APB requester.
// Adds a bounded wait-state timeout so a silent completer cannot hang the initiator.
module apb_master_bridge #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int unsigned CntW     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned CntLastI = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CntW-1:0] CntLast = CntW'(CntLastI);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e            r_state, w_state_next;
    logic [CntW-1:0]   r_cnt, w_cnt;
    logic              r_psel, w_psel;
    logic              r_penable, w_penable;
    logic              r_cmd_ready, w_cmd_ready;
    logic              r_rsp_valid, w_rsp_valid;
    logic              r_pwrite, w_pwrite;
    logic [ADDR_W-1:0] r_paddr, w_paddr;
    logic [DATA_W-1:0] r_pwdata, w_pwdata;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
    logic              r_rsp_err, w_rsp_err;
    logic              r_rsp_timeout, w_rsp_timeout;
    logic              w_timeout_hit;

    assign w_timeout_hit = (TIMEOUT_CYC != 0) && (r_cnt == CntLast);

    always_comb begin
        w_state_next  = r_state;
        w_cnt         = r_cnt;
        w_pwrite      = r_pwrite;
        w_paddr       = r_paddr;
        w_pwdata      = r_pwdata;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_rsp_timeout = r_rsp_timeout;

        case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    w_state_next = StSetup;
                    w_pwrite     = cmd_write;
                    w_paddr      = cmd_addr;
                    w_pwdata     = cmd_wdata;
                end
            end
            StSetup: begin
                w_state_next = StAccess;
                w_cnt        = '0;
            end
            StAccess: begin
                // Completion wins over a timeout landing in the same cycle.
                if (PREADY) begin
                    w_state_next  = StResp;
                    w_rsp_rdata   = r_pwrite ? '0 : PRDATA;
                    w_rsp_err     = PSLVERR;
                    w_rsp_timeout = 1'b0;
                end else if (w_timeout_hit) begin
                    w_state_next  = StResp;
                    w_rsp_rdata   = '0;
                    w_rsp_err     = 1'b1;
                    w_rsp_timeout = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        // Decoding the next state keeps every control output a plain flop.
        w_psel      = (w_state_next == StSetup) || (w_state_next == StAccess);
        w_penable   = (w_state_next == StAccess);
        w_cmd_ready = (w_state_next == StIdle);
        w_rsp_valid = (w_state_next == StResp);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_cmd_ready   <= w_cmd_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_pwrite      <= w_pwrite;
            r_paddr       <= w_paddr;
            r_pwdata      <= w_pwdata;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_rsp_timeout <= w_rsp_timeout;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;

endmodule
